// File: rtl/nonce_sweeper.sv
// nonce_sweeper: feeds nonce-stamped headers to a double-SHA-256 core.
// Optional MINER_WATCHDOG_EN: WAIT-state watchdog that retries the nonce.
module nonce_sweeper #(
  parameter int unsigned STRIDE         = 1,
  parameter bit          SWAP_HASH      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 512
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [607:0] work_prefix,
  input  logic [255:0] work_target,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic         work_abort,
  output logic [639:0] header,
  output logic         hash_start,
  input  logic         hash_done,
  input  logic [255:0] hash_in,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         result_found,
  output logic [31:0]  result_nonce,
  output logic [255:0] result_hash,
  output logic [31:0]  hashes_done,
  output logic         timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_REPORT
  } state_t;

  state_t         r_state;
  logic [607:0]   r_prefix;
  logic [255:0]   r_target;
  logic [31:0]    r_nonce;
  logic [31:0]    r_end;
  logic [255:0]   r_hash_q;
  logic           r_work_ready;
  logic           r_hash_start;
  logic           r_result_valid;
  logic           r_result_found;
  logic [31:0]    r_result_nonce;
  logic [255:0]   r_result_hash;
  logic [31:0]    r_hashes_done;
  logic           r_timeout_err;

`ifdef MINER_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0] r_wd;
`endif

  function automatic logic [255:0] byte_rev(input logic [255:0] d);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      r[8*i +: 8] = d[8*(31-i) +: 8];
    return r;
  endfunction

  logic [255:0] w_hv;
  logic         w_hit;
  logic [32:0]  w_next33;
  logic         w_last;
  logic         w_empty;

  // Compare path and last-nonce test; 33-bit sum so FFFFFFFF never wraps
  always_comb begin
    w_hv     = SWAP_HASH ? byte_rev(r_hash_q) : r_hash_q;
    w_hit    = (w_hv <= r_target);
    w_next33 = {1'b0, r_nonce} + 33'(STRIDE);
    w_last   = (w_next33 > {1'b0, r_end});
    w_empty  = (nonce_start > nonce_end);
  end

  assign header = {r_prefix, r_nonce[7:0], r_nonce[15:8],
                   r_nonce[23:16], r_nonce[31:24]};
  assign work_ready   = r_work_ready;
  assign hash_start   = r_hash_start;
  assign result_valid = r_result_valid;
  assign result_found = r_result_found;
  assign result_nonce = r_result_nonce;
  assign result_hash  = r_result_hash;
  assign hashes_done  = r_hashes_done;
  assign timeout_err  = r_timeout_err;

  // Dispatcher FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_prefix       <= '0;
      r_target       <= '0;
      r_nonce        <= '0;
      r_end          <= '0;
      r_hash_q       <= '0;
      r_work_ready   <= 1'b1;
      r_hash_start   <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_found <= 1'b0;
      r_result_nonce <= '0;
      r_result_hash  <= '0;
      r_hashes_done  <= '0;
      r_timeout_err  <= 1'b0;
`ifdef MINER_WATCHDOG_EN
      r_wd           <= '0;
`endif
    end else begin
      r_hash_start <= 1'b0;
      if (work_abort && r_state != S_IDLE) begin
        r_state        <= S_IDLE;
        r_work_ready   <= 1'b1;
        r_result_valid <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (work_valid && r_work_ready) begin
              r_prefix      <= work_prefix;
              r_target      <= work_target;
              r_nonce       <= nonce_start;
              r_end         <= nonce_end;
              r_hashes_done <= '0;
              r_timeout_err <= 1'b0;
              r_work_ready  <= 1'b0;
              if (w_empty) begin
                r_state        <= S_REPORT;
                r_result_valid <= 1'b1;
                r_result_found <= 1'b0;
                r_result_nonce <= nonce_start;
                r_result_hash  <= '0;
              end else begin
                r_state      <= S_LAUNCH;
                r_hash_start <= 1'b1;
              end
            end
          end
          S_LAUNCH: begin
            r_state <= S_WAIT;
`ifdef MINER_WATCHDOG_EN
            r_wd    <= '0;
`endif
          end
          S_WAIT: begin
            if (hash_done) begin
              r_hash_q <= hash_in;
              r_state  <= S_CHECK;
            end
`ifdef MINER_WATCHDOG_EN
            else if (r_wd == WD_LAST) begin
              r_timeout_err <= 1'b1;
              r_state       <= S_LAUNCH;
              r_hash_start  <= 1'b1;
            end else begin
              r_wd <= r_wd + 1'b1;
            end
`endif
          end
          S_CHECK: begin
            if (r_hashes_done != 32'hFFFF_FFFF)
              r_hashes_done <= r_hashes_done + 32'd1;
            if (w_hit || w_last) begin
              r_state        <= S_REPORT;
              r_result_valid <= 1'b1;
              r_result_found <= w_hit;
              r_result_nonce <= r_nonce;
              r_result_hash  <= w_hv;
            end else begin
              r_nonce      <= w_next33[31:0];
              r_state      <= S_LAUNCH;
              r_hash_start <= 1'b1;
            end
          end
          S_REPORT: begin
            if (result_ready) begin
              r_result_valid <= 1'b0;
              r_work_ready   <= 1'b1;
              r_state        <= S_IDLE;
            end
          end
          default: begin
            r_state      <= S_IDLE;
            r_work_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nonce_sweeper.sv
// tb_nonce_sweeper: randomized jobs against a range-walk reference model,
// plus directed empty-range, wrap, abort, reset and watchdog cases.
module tb_nonce_sweeper;
  localparam int unsigned STRIDE = 1;
  localparam int unsigned TMO    = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         work_valid, work_ready, work_abort;
  logic [607:0] work_prefix;
  logic [255:0] work_target;
  logic [31:0]  nonce_start, nonce_end;
  logic [639:0] header;
  logic         hash_start, hash_done;
  logic [255:0] hash_in;
  logic         result_valid, result_ready, result_found;
  logic [31:0]  result_nonce;
  logic [255:0] result_hash;
  logic [31:0]  hashes_done;
  logic         timeout_err;

  always #5 clk = ~clk;

  nonce_sweeper #(
    .STRIDE(STRIDE), .SWAP_HASH(1'b1), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .work_valid(work_valid), .work_ready(work_ready),
    .work_prefix(work_prefix), .work_target(work_target),
    .nonce_start(nonce_start), .nonce_end(nonce_end),
    .work_abort(work_abort), .header(header),
    .hash_start(hash_start), .hash_done(hash_done),
    .hash_in(hash_in), .result_valid(result_valid),
    .result_ready(result_ready), .result_found(result_found),
    .result_nonce(result_nonce), .result_hash(result_hash),
    .hashes_done(hashes_done), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stand-in for the SHA core: any deterministic mix of nonce and prefix
  function automatic logic [255:0] hashfn(input logic [31:0] n,
                                          input logic [607:0] p);
    logic [255:0] h;
    h = '0;
    for (int i = 0; i < 8; i++)
      h[32*i +: 32] = (((n ^ p[32*i +: 32]) + 32'(i)) * 32'h9E3779B1)
                      ^ (n >> i);
    return h;
  endfunction

  logic [31:0]  lq[$];
  int           launch_cnt = 0;
  logic [607:0] last_prefix = '0;
  int           miner_lat = 0;
  int           skip_until = 0;

  // Miner model: records each launch, answers after a latency
  initial begin
    logic [31:0]  n;
    logic [607:0] p;
    int           k;
    hash_done = 1'b0;
    hash_in   = '0;
    forever begin
      @(posedge clk); #1;
      if (hash_start === 1'b1) begin
        n = {header[7:0], header[15:8], header[23:16], header[31:24]};
        p = header[639:32];
        lq.push_back(n);
        last_prefix = p;
        launch_cnt++;
        if (launch_cnt > skip_until) begin
          k = miner_lat;
          @(posedge clk); #1;
          repeat (k) begin @(posedge clk); #1; end
          hash_in   = hashfn(n, p);
          hash_done = 1'b1;
          @(posedge clk); #1;
          hash_done = 1'b0;
          hash_in   = {8{$urandom}};
        end
      end
    end
  end

  task automatic run_job(input string nm, input logic [607:0] p,
                         input logic [255:0] t, input logic [31:0] s,
                         input logic [31:0] e, input logic ab);
    logic [31:0]  exp_l[$];
    logic         ef;
    logic [31:0]  en;
    logic [255:0] eh;
    logic [31:0]  ecnt;
    logic [255:0] raw, hv;
    int           base, cyc, got;
    ef = 1'b0; en = s; eh = '0; ecnt = '0;
    if (s <= e) begin
      for (longint n = s; n <= longint'(e); n += STRIDE) begin
        raw = hashfn(32'(n), p);
        hv  = {<<8{raw}};
        exp_l.push_back(32'(n));
        ecnt++;
        en = 32'(n);
        eh = hv;
        if (hv <= t) begin
          ef = 1'b1;
          break;
        end
      end
    end
    base = launch_cnt;
    chk({nm, " ready"}, work_ready, 1);
    work_prefix = p; work_target = t;
    nonce_start = s; nonce_end = e;
    work_valid = 1'b1; work_abort = ab;
    @(posedge clk); #1;
    work_valid = 1'b0; work_abort = 1'b0;
    if (s > e) chk({nm, " empty valid"}, result_valid, 1);
    cyc = 0;
    while (result_valid !== 1'b1 && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " budget"}, cyc < 4000, 1);
    for (int r = 0; r < 2; r++) begin
      chk({nm, " valid"}, result_valid, 1);
      chk({nm, " found"}, result_found, ef);
      chk({nm, " nonce"}, result_nonce, en);
      chk({nm, " hash"}, result_hash, eh);
      chk({nm, " count"}, hashes_done, ecnt);
      chk({nm, " tmo"}, timeout_err, 0);
      @(posedge clk); #1;
    end
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    chk({nm, " drop"}, result_valid, 0);
    chk({nm, " idle"}, work_ready, 1);
    got = launch_cnt - base;
    chk({nm, " launches"}, got, exp_l.size());
    for (int i = 0; i < exp_l.size() && i < got; i++)
      chk({nm, " lnonce"}, lq[base+i], exp_l[i]);
    if (got > 0) chk({nm, " prefix"}, last_prefix, p);
  endtask

  initial begin
    #900000;
    $display("FAIL global time limit");
    $fatal(1, "time limit");
  end

  initial begin
    logic [607:0] p;
    logic [255:0] t;
    logic [31:0]  s, e;
    int           len, base, cyc;
    logic         seen;
    work_valid = 0; work_abort = 0; result_ready = 0;
    work_prefix = '0; work_target = '0;
    nonce_start = '0; nonce_end = '0;
    for (int w = 0; w < 19; w++) p[32*w +: 32] = $urandom;

    repeat (3) @(posedge clk);
    #1;
    chk("rst ready", work_ready, 1);
    chk("rst start", hash_start, 0);
    chk("rst valid", result_valid, 0);
    chk("rst header", header[255:0], 0);
    chk("rst found", result_found, 0);
    chk("rst nonce", result_nonce, 0);
    chk("rst hash", result_hash, 0);
    chk("rst count", hashes_done, 0);
    chk("rst tmo", timeout_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    miner_lat = 1;
    run_job("first", p, '1, 32'd0, 32'd3, 1'b1);
    chk("first nonce0", result_nonce, 0);
    chk("first one", hashes_done, 1);
    run_job("miss", p, '0, 32'd5, 32'd7, 1'b0);
    run_job("wrap", p, '0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
    chk("wrap last", result_nonce, 32'hFFFF_FFFF);
    run_job("empty", p, '1, 32'd10, 32'd9, 1'b0);

    for (int j = 0; j < 8; j++) begin
      for (int w = 0; w < 19; w++) p[32*w +: 32] = $urandom;
      t = '1;
      t[255:224] = $urandom;
      s = $urandom;
      len = $urandom_range(0, 7);
      miner_lat = $urandom_range(0, 3);
      if (j == 6) s = 32'hFFFF_FFFB;
      e = (s > 32'hFFFF_FFF8) ? 32'hFFFF_FFFF : s + 32'(len);
      if (j == 3) e = s - 32'd1;
      run_job("rand", p, t, s, e, 1'b0);
    end

    miner_lat = 30;
    base = launch_cnt;
    work_prefix = p; work_target = '0;
    nonce_start = 32'd0; nonce_end = 32'd100;
    work_valid = 1'b1;
    @(posedge clk); #1;
    work_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    work_abort = 1'b1;
    @(posedge clk); #1;
    work_abort = 1'b0;
    chk("abort ready", work_ready, 1);
    chk("abort valid", result_valid, 0);
    seen = 1'b0;
    repeat (45) begin
      @(posedge clk); #1;
      if (result_valid !== 1'b0 || hash_start !== 1'b0) seen = 1'b1;
    end
    chk("abort quiet", seen, 0);
    chk("abort launches", launch_cnt - base, 1);

    miner_lat = 5;
    work_valid = 1'b1;
    @(posedge clk); #1;
    work_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst ready", work_ready, 1);
    chk("mrst valid", result_valid, 0);
    chk("mrst count", hashes_done, 0);
    chk("mrst start", hash_start, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mrst idle", result_valid, 0);

`ifdef MINER_WATCHDOG_EN
    miner_lat = 0;
    base = launch_cnt;
    skip_until = launch_cnt + 1;
    work_target = '1;
    nonce_start = 32'h1234; nonce_end = 32'h1234;
    work_valid = 1'b1;
    @(posedge clk); #1;
    work_valid = 1'b0;
    cyc = 0;
    while (result_valid !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("wd budget", cyc < 200, 1);
    chk("wd flag", timeout_err, 1);
    chk("wd found", result_found, 1);
    chk("wd nonce", result_nonce, 32'h1234);
    chk("wd count", hashes_done, 1);
    chk("wd launches", launch_cnt - base, 2);
    chk("wd retry", lq[lq.size()-1], 32'h1234);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
`else
    cyc = 0;
    chk("no wd", timeout_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
